counter_updown_mod: RTL and testbench

Parametrised successor to the team's single-direction enable counter. It counts up or down, per cycle, within a programmable modulus [0, MAX_VAL]. It supports synchronous load, and wrap or saturate at either boundary. It reports boundary events through a registered pulse and a sticky flag. It is used as the generic event/timeout/index counter in control paths and is formally checkable stand-alone.

---
 rtl/counter_updown_mod.sv | 105 ++++++++++
 tb/tb_counter_updown_mod.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/counter_updown_mod.sv
// Up/down counter over [0, MAX_VAL] with synchronous load, wrap or saturate at
// the boundaries, a registered boundary pulse, a load-clamp pulse and a sticky flag.
module counter_updown_mod #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] MAX_VAL   = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter bit               SATURATE  = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_up,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_clr_sticky,
    output logic [WIDTH-1:0] o_q,
    output logic             o_at_max,
    output logic             o_at_min,
    output logic             o_bound,
    output logic             o_load_err,
    output logic             o_bound_sticky
);

    if (WIDTH < 2) begin : g_bad_width
        $error("counter_updown_mod: WIDTH must be at least 2");
    end
    if (MAX_VAL == '0) begin : g_bad_max
        $error("counter_updown_mod: MAX_VAL must be at least 1");
    end
    if (RESET_VAL > MAX_VAL) begin : g_bad_reset
        $error("counter_updown_mod: RESET_VAL exceeds MAX_VAL");
    end

    logic [WIDTH-1:0] q_next;
    logic             hit_bound;
    logic             load_over;

    assign o_at_max = (o_q == MAX_VAL);
    assign o_at_min = (o_q == '0);

    // Load beats count; the >= / == compares keep the result inside [0, MAX_VAL]
    // without ever needing a carry bit.
    always_comb begin
        q_next    = o_q;
        hit_bound = 1'b0;
        load_over = 1'b0;
        if (i_load) begin
            if (i_load_val > MAX_VAL) begin
                q_next    = MAX_VAL;
                load_over = 1'b1;
            end else begin
                q_next = i_load_val;
            end
        end else if (i_en) begin
            if (i_up) begin
                if (o_q >= MAX_VAL) begin
                    hit_bound = 1'b1;
                    q_next    = SATURATE ? MAX_VAL : '0;
                end else begin
                    q_next = o_q + 1'b1;
                end
            end else begin
                if (o_q == '0) begin
                    hit_bound = 1'b1;
                    q_next    = SATURATE ? '0 : MAX_VAL;
                end else begin
                    q_next = o_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_q            <= RESET_VAL;
            o_bound        <= 1'b0;
            o_load_err     <= 1'b0;
            o_bound_sticky <= 1'b0;
        end else begin
            o_q        <= q_next;
            o_bound    <= hit_bound;
            o_load_err <= load_over;
            // A new event outranks a clear issued in the same cycle.
            if (hit_bound) begin
                o_bound_sticky <= 1'b1;
            end else if (i_clr_sticky) begin
                o_bound_sticky <= 1'b0;
            end
        end
    end

`ifndef SYNTHESIS
    a_in_range: assert property (@(posedge i_clk) disable iff (i_rst)
        o_q <= MAX_VAL);
    a_bound_sticky: assert property (@(posedge i_clk) disable iff (i_rst)
        o_bound |-> o_bound_sticky);
    a_load_err_max: assert property (@(posedge i_clk) disable iff (i_rst)
        o_load_err |-> (o_q == MAX_VAL));
    if (!SATURATE) begin : g_wrap_prop
        a_up_wrap: assert property (@(posedge i_clk) disable iff (i_rst)
            (i_en && i_up && !i_load && o_q == MAX_VAL) |=> (o_q == '0));
    end
`endif

endmodule

// File: tb/tb_counter_updown_mod.sv
// Scoreboard bench: three counter instances (wrap, saturate, RESET_VAL=3), directed
// steps push expected outputs, a separate monitor pops and compares each cycle.
module tb_counter_updown_mod;

    typedef struct packed {
        logic       rst;
        logic       en;
        logic       up;
        logic       load;
        logic [3:0] val;
        logic       clr;
    } stim_t;

    typedef struct {
        int         id;
        logic [3:0] q;
        logic       b;
        logic       l;
        logic       st;
    } exp_t;

    logic       clk = 1'b0;
    stim_t      s [3];
    logic [3:0] q [3];
    logic       amax [3];
    logic       amin [3];
    logic       bnd [3];
    logic       lerr [3];
    logic       stk [3];

    exp_t sb [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    counter_updown_mod #(.WIDTH(4), .MAX_VAL(4'd9), .RESET_VAL(4'd0), .SATURATE(1'b0)) u_wrap (
        .i_clk(clk), .i_rst(s[0].rst), .i_en(s[0].en), .i_up(s[0].up), .i_load(s[0].load),
        .i_load_val(s[0].val), .i_clr_sticky(s[0].clr), .o_q(q[0]), .o_at_max(amax[0]),
        .o_at_min(amin[0]), .o_bound(bnd[0]), .o_load_err(lerr[0]), .o_bound_sticky(stk[0]));

    counter_updown_mod #(.WIDTH(4), .MAX_VAL(4'd9), .RESET_VAL(4'd0), .SATURATE(1'b1)) u_sat (
        .i_clk(clk), .i_rst(s[1].rst), .i_en(s[1].en), .i_up(s[1].up), .i_load(s[1].load),
        .i_load_val(s[1].val), .i_clr_sticky(s[1].clr), .o_q(q[1]), .o_at_max(amax[1]),
        .o_at_min(amin[1]), .o_bound(bnd[1]), .o_load_err(lerr[1]), .o_bound_sticky(stk[1]));

    counter_updown_mod #(.WIDTH(4), .MAX_VAL(4'd9), .RESET_VAL(4'd3), .SATURATE(1'b0)) u_rst3 (
        .i_clk(clk), .i_rst(s[2].rst), .i_en(s[2].en), .i_up(s[2].up), .i_load(s[2].load),
        .i_load_val(s[2].val), .i_clr_sticky(s[2].clr), .o_q(q[2]), .o_at_max(amax[2]),
        .o_at_min(amin[2]), .o_bound(bnd[2]), .o_load_err(lerr[2]), .o_bound_sticky(stk[2]));

    function automatic stim_t mk(logic rst, logic en, logic up, logic load,
                                 logic [3:0] val, logic clr);
        stim_t t;
        t.rst = rst; t.en = en; t.up = up; t.load = load; t.val = val; t.clr = clr;
        return t;
    endfunction

    function automatic void check(string name, int id, int act, int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0d expected %0d", name, id, act, exp);
        end
    endfunction

    // Drive one cycle on one instance; the others idle and hold.
    task automatic step(input int id, input stim_t st, input logic [3:0] eq,
                        input logic eb, input logic el, input logic es);
        exp_t e;
        @(negedge clk);
        for (int k = 0; k < 3; k++) s[k] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        s[id] = st;
        e.id = id; e.q = eq; e.b = eb; e.l = el; e.st = es;
        sb.push_back(e);
        @(posedge clk);
    endtask

    // Monitor: every output cycle with a pending expectation is compared.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("q",        e.id, int'(q[e.id]),    int'(e.q));
                check("bound",    e.id, int'(bnd[e.id]),  int'(e.b));
                check("load_err", e.id, int'(lerr[e.id]), int'(e.l));
                check("sticky",   e.id, int'(stk[e.id]),  int'(e.st));
                check("at_max",   e.id, int'(amax[e.id]), int'(e.q == 4'd9));
                check("at_min",   e.id, int'(amin[e.id]), int'(e.q == 4'd0));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < 3; k++) s[k] = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        repeat (2) @(posedge clk);

        // Wrap instance: 12 up counts from reset
        step(0, mk(1, 0, 0, 0, 4'd0, 0), 4'd0, 0, 0, 0);
        for (int i = 1; i <= 12; i++)
            step(0, mk(0, 1, 1, 0, 4'd0, 0), 4'(i % 10), (i == 10), 0, (i >= 10));
        // Sticky race: event and clear together, set wins
        step(0, mk(0, 0, 0, 1, 4'd9, 0), 4'd9, 0, 0, 1);
        step(0, mk(0, 0, 0, 0, 4'd0, 1), 4'd9, 0, 0, 0);
        step(0, mk(0, 1, 1, 0, 4'd0, 1), 4'd0, 1, 0, 1);
        step(0, mk(0, 0, 0, 0, 4'd0, 1), 4'd0, 0, 0, 0);
        // Down wrap at 0
        step(0, mk(0, 1, 0, 0, 4'd0, 0), 4'd9, 1, 0, 1);
        step(0, mk(0, 0, 0, 0, 4'd0, 1), 4'd9, 0, 0, 0);
        // Load clamp with en ignored, then legal load
        step(0, mk(0, 1, 1, 1, 4'd13, 0), 4'd9, 0, 1, 0);
        step(0, mk(0, 0, 0, 1, 4'd5, 0), 4'd5, 0, 0, 0);
        // Direction change and hold
        step(0, mk(0, 1, 1, 0, 4'd0, 0), 4'd6, 0, 0, 0);
        step(0, mk(0, 1, 1, 0, 4'd0, 0), 4'd7, 0, 0, 0);
        step(0, mk(0, 0, 1, 0, 4'd0, 0), 4'd7, 0, 0, 0);
        step(0, mk(0, 1, 0, 0, 4'd0, 0), 4'd6, 0, 0, 0);
        step(0, mk(0, 1, 0, 0, 4'd0, 0), 4'd5, 0, 0, 0);
        step(0, mk(0, 1, 0, 0, 4'd0, 0), 4'd4, 0, 0, 0);

        // Saturating instance: count down from 2, then hold at 0 and 9
        step(1, mk(1, 0, 0, 0, 4'd0, 0), 4'd0, 0, 0, 0);
        step(1, mk(0, 0, 0, 1, 4'd2, 0), 4'd2, 0, 0, 0);
        step(1, mk(0, 1, 0, 0, 4'd0, 0), 4'd1, 0, 0, 0);
        step(1, mk(0, 1, 0, 0, 4'd0, 0), 4'd0, 0, 0, 0);
        step(1, mk(0, 1, 0, 0, 4'd0, 0), 4'd0, 1, 0, 1);
        step(1, mk(0, 1, 0, 0, 4'd0, 0), 4'd0, 1, 0, 1);
        step(1, mk(0, 0, 0, 1, 4'd9, 0), 4'd9, 0, 0, 1);
        step(1, mk(0, 1, 1, 0, 4'd0, 0), 4'd9, 1, 0, 1);
        step(1, mk(0, 1, 1, 0, 4'd0, 0), 4'd9, 1, 0, 1);
        step(1, mk(0, 0, 0, 1, 4'd15, 0), 4'd9, 0, 1, 1);
        step(1, mk(0, 0, 0, 0, 4'd0, 0), 4'd9, 0, 0, 1);

        // RESET_VAL=3 instance: reset mid-count overrides load and en
        step(2, mk(1, 0, 0, 0, 4'd0, 0), 4'd3, 0, 0, 0);
        step(2, mk(0, 0, 0, 1, 4'd9, 0), 4'd9, 0, 0, 0);
        step(2, mk(0, 1, 1, 0, 4'd0, 0), 4'd0, 1, 0, 1);
        step(2, mk(0, 0, 0, 1, 4'd7, 0), 4'd7, 0, 0, 1);
        step(2, mk(1, 1, 1, 1, 4'd2, 0), 4'd3, 0, 0, 0);
        step(2, mk(0, 0, 0, 0, 4'd0, 0), 4'd3, 0, 0, 0);

        @(negedge clk);
        for (int k = 0; k < 3; k++) s[k] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", 0, sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
